axi_lite_master: RTL

- Single-outstanding AXI4-Lite initiator (32-bit address and data).
- Converts a simple command/response interface into AXI-Lite write (AW/W/B) or read (AR/R) transactions.
- Drives the on-chip AXI-Lite peripheral slaves, such as the LED register slave, from local control logic or a test sequencer.
- Accepts one command at a time and returns one response per command.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_lite_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master state encoding, default widths.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W         = 32;
  localparam int unsigned AXI_DATA_W         = 32;
  localparam int unsigned AXI_TIMEOUT_CYCLES = 256;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WR_REQ  = 6'b000010,
    ST_WR_RESP = 6'b000100,
    ST_RD_REQ  = 6'b001000,
    ST_RD_DATA = 6'b010000,
    ST_RSP     = 6'b100000
  } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: command/response port to AW/W/B or AR/R.
// Optional transaction timeout enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = AXI_ADDR_W,
  parameter int unsigned DATA_W         = AXI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = AXI_TIMEOUT_CYCLES
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e              state_q, state_n;
  logic                cmd_ready_q, cmd_ready_n;
  logic                aw_valid_q, aw_valid_n, w_valid_q, w_valid_n;
  logic                aw_done_q, aw_done_n, w_done_q, w_done_n;
  logic                b_ready_q, b_ready_n, ar_valid_q, ar_valid_n, r_ready_q, r_ready_n;
  logic                rsp_valid_q, rsp_valid_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n, rdata_q, rdata_n;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_n;
  logic [1:0]          resp_q, resp_n;
  logic                accept;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             timeout_q, timeout_n;
  logic             busy;
`endif

  assign accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;

  always_comb begin
    state_n     = state_q;
    cmd_ready_n = cmd_ready_q;
    aw_valid_n  = aw_valid_q;
    w_valid_n   = w_valid_q;
    aw_done_n   = aw_done_q;
    w_done_n    = w_done_q;
    b_ready_n   = b_ready_q;
    ar_valid_n  = ar_valid_q;
    r_ready_n   = r_ready_q;
    rsp_valid_n = rsp_valid_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    rdata_n     = rdata_q;
    resp_n      = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_n = 1'b1;
        if (accept) begin
          cmd_ready_n = 1'b0;
          addr_n      = cmd_addr;
          wdata_n     = cmd_wdata;
          wstrb_n     = cmd_wstrb;
          if (cmd_write) begin
            state_n    = ST_WR_REQ;
            aw_valid_n = 1'b1;
            w_valid_n  = 1'b1;
            aw_done_n  = 1'b0;
            w_done_n   = 1'b0;
          end else begin
            state_n    = ST_RD_REQ;
            ar_valid_n = 1'b1;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W retire independently; both flags must be set before B.
        if (aw_valid_q && AWREADY) begin
          aw_valid_n = 1'b0;
          aw_done_n  = 1'b1;
        end
        if (w_valid_q && WREADY) begin
          w_valid_n = 1'b0;
          w_done_n  = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          state_n   = ST_WR_RESP;
          b_ready_n = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (b_ready_q && BVALID) begin
          b_ready_n   = 1'b0;
          resp_n      = BRESP;
          rdata_n     = '0;
          rsp_valid_n = 1'b1;
          state_n     = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (ar_valid_q && ARREADY) begin
          ar_valid_n = 1'b0;
          r_ready_n  = 1'b1;
          state_n    = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (r_ready_q && RVALID) begin
          r_ready_n   = 1'b0;
          resp_n      = RRESP;
          rdata_n     = RDATA;
          rsp_valid_n = 1'b1;
          state_n     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    busy      = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    cnt_n     = cnt_q;
    timeout_n = timeout_q;
    if (accept) begin
      cnt_n     = '0;
      timeout_n = 1'b0;
    end else if (busy) begin
      cnt_n = cnt_q + 1'b1;
    end
    // Abort overrides whatever handshake the case above would have taken.
    if (busy && (cnt_q == CNT_MAX)) begin
      aw_valid_n  = 1'b0;
      w_valid_n   = 1'b0;
      b_ready_n   = 1'b0;
      ar_valid_n  = 1'b0;
      r_ready_n   = 1'b0;
      aw_done_n   = 1'b0;
      w_done_n    = 1'b0;
      resp_n      = RESP_SLVERR;
      rdata_n     = '0;
      rsp_valid_n = 1'b1;
      timeout_n   = 1'b1;
      state_n     = ST_RSP;
    end
`endif
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_n;
      cmd_ready_q <= cmd_ready_n;
      aw_valid_q  <= aw_valid_n;
      w_valid_q   <= w_valid_n;
      aw_done_q   <= aw_done_n;
      w_done_q    <= w_done_n;
      b_ready_q   <= b_ready_n;
      ar_valid_q  <= ar_valid_n;
      r_ready_q   <= r_ready_n;
      rsp_valid_q <= rsp_valid_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      rdata_q     <= rdata_n;
      resp_q      <= resp_n;
    end
  end

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_n;
      timeout_q <= timeout_n;
    end
  end
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign AWADDR    = addr_q;
  assign AWVALID   = aw_valid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = w_valid_q;
  assign BREADY    = b_ready_q;
  assign ARADDR    = addr_q;
  assign ARVALID   = ar_valid_q;
  assign RREADY    = r_ready_q;

endmodule
